// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   UART receiver driven by a 16x-oversampling baud tick. Deserialises the
//   asynchronous rx line (LSB first) into DBIT-wide words, optionally checks
//   an even/odd parity bit, and reports framing and parity errors alongside
//   a one-clock done strobe.
//
// Parameters
//   DBIT     data bits per frame (5..9)
//   SB_TICK  stop-bit length in s_ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//   PARITY   0 = none, 1 = even, 2 = odd
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   rx            asynchronous serial line, idle high
//   s_tick        one-clock pulse at 16x the baud rate
//   dout          last received data word (held until the next word)
//   rx_done_tick  one-clock pulse: dout / frame_err / parity_err are valid
//   frame_err     stop bit was sampled low for the word just completed
//   parity_err    parity mismatch for the word just completed
//   busy          high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state_r;
    logic [4:0]      s_r;
    logic [N_W-1:0]  n_r;
    logic [DBIT-1:0] shift_r;
    logic            par_bit_r;
    logic            rx_meta_r;
    logic            rx_sync_r;

    // Parity check: the data bits plus the received parity bit must XOR to 0
    // for even parity and to 1 for odd parity; never flags when disabled.
    function automatic logic parity_mismatch(input logic [DBIT-1:0] data,
                                             input logic            pbit);
        logic odd_sel;
        odd_sel = (PARITY == 2) ? 1'b1 : 1'b0;
        if (PARITY != 0) begin
            parity_mismatch = (^data) ^ pbit ^ odd_sel;
        end else begin
            parity_mismatch = 1'b0;
        end
    endfunction

    // Two-flop synchroniser for the asynchronous rx pin; resets to idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM with registered outputs; counters advance only on s_tick,
    // except the IDLE exit which reacts to the start edge immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            s_r          <= 5'd0;
            n_r          <= '0;
            shift_r      <= '0;
            par_bit_r    <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // The done strobe lasts one clock regardless of s_tick.
            rx_done_tick <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rx_sync_r) begin
                        state_r <= START;
                        s_r     <= 5'd0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        // Eight ticks in is the middle of the start bit.
                        if (s_r == 5'd7) begin
                            if (!rx_sync_r) begin
                                state_r <= DATA;
                                s_r     <= 5'd0;
                                n_r     <= '0;
                            end else begin
                                // Too short to be a start bit: a glitch.
                                state_r <= IDLE;
                                s_r     <= 5'd0;
                                busy    <= 1'b0;
                            end
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_r == 5'd15) begin
                            s_r     <= 5'd0;
                            shift_r <= {rx_sync_r, shift_r[DBIT-1:1]};
                            if (n_r == N_W'(DBIT - 1)) begin
                                state_r <= (PARITY != 0) ? PAR : STOP;
                            end else begin
                                n_r <= n_r + N_W'(1);
                            end
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                PAR: begin
                    if (s_tick) begin
                        if (s_r == 5'd15) begin
                            par_bit_r <= rx_sync_r;
                            s_r       <= 5'd0;
                            state_r   <= STOP;
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_r == 5'(SB_TICK - 1)) begin
                            state_r      <= IDLE;
                            s_r          <= 5'd0;
                            busy         <= 1'b0;
                            dout         <= shift_r;
                            frame_err    <= ~rx_sync_r;
                            parity_err   <= parity_mismatch(shift_r, par_bit_r);
                            rx_done_tick <= 1'b1;
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    s_r     <= 5'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//   Three receivers (no parity, even, odd) share clock, reset and s_tick;
//   each has its own rx line. A frame-level model queues the expected
//   {parity_err, frame_err, dout} for every frame sent; a per-cycle monitor
//   pops it on each done strobe and checks that outputs hold in between.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [2:0] rx_line;
    logic [7:0] dout_w [3];
    logic [2:0] done_w;
    logic [2:0] ferr_w;
    logic [2:0] perr_w;
    logic [2:0] busy_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_sampler #(
            .DBIT   (8),
            .SB_TICK(16),
            .PARITY (g)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .rx          (rx_line[g]),
            .s_tick      (s_tick),
            .dout        (dout_w[g]),
            .rx_done_tick(done_w[g]),
            .frame_err   (ferr_w[g]),
            .parity_err  (perr_w[g]),
            .busy        (busy_w[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] expq [3][$];
    logic [9:0] last_v [3];
    logic [2:0] prev_done;
    logic [2:0] busy_seen;
    int         done_cnt [3];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // s_tick: one clock high out of every four
    initial begin
        int div;
        div    = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            div    = (div + 1) % 4;
            s_tick = (div == 0);
        end
    end

    // Wait for k s_tick edges, then step 1 time unit past the edge.
    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            expq[k].delete();
            last_v[k] = 10'd0;
        end
        prev_done = 3'b000;
    endtask

    // Send one 8-bit frame on line k (parity bit only for k != 0).
    task automatic send_frame(input int k, input logic [7:0] data,
                              input logic pbit, input logic stop_ok, input int gap);
        logic pe;
        logic odd;
        odd = (k == 2);
        pe  = (k == 0) ? 1'b0 : ((^data) ^ pbit ^ odd);
        expq[k].push_back({pe, ~stop_ok, data});
        rx_line[k] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_line[k] = data[i];
            wait_ticks(16);
        end
        if (k != 0) begin
            rx_line[k] = pbit;
            wait_ticks(16);
        end
        if (stop_ok) begin
            rx_line[k] = 1'b1;
            wait_ticks(16);
        end else begin
            // Low only long enough to cover the mid-bit sample.
            rx_line[k] = 1'b0;
            wait_ticks(9);
            rx_line[k] = 1'b1;
            wait_ticks(7);
        end
        rx_line[k] = 1'b1;
        if (!stop_ok && gap < 16) gap = 16;
        if (gap > 0) wait_ticks(gap);
    endtask

    // Per-cycle monitor: pop the model on done, otherwise outputs must hold.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (busy_w[k]) busy_seen[k] = 1'b1;
            if (done_w[k]) begin
                check("done_one_clk", k, {31'd0, prev_done[k]}, 32'd0);
                check("busy_low_at_done", k, {31'd0, busy_w[k]}, 32'd0);
                check("done_expected", k, {31'd0, (expq[k].size() != 0)}, 32'd1);
                if (expq[k].size() != 0) last_v[k] = expq[k].pop_front();
                done_cnt[k]++;
            end
            check("dout", k, {24'd0, dout_w[k]}, {24'd0, last_v[k][7:0]});
            check("frame_err", k, {31'd0, ferr_w[k]}, {31'd0, last_v[k][8]});
            check("parity_err", k, {31'd0, perr_w[k]}, {31'd0, last_v[k][9]});
            prev_done[k] = done_w[k];
        end
    end

    initial begin
        int         cnt;
        logic [7:0] d;
        reset   = 1'b0;
        rx_line = 3'b111;
        busy_seen = 3'b000;
        for (int k = 0; k < 3; k++) done_cnt[k] = 0;
        clear_model();

        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_dout", k, {24'd0, dout_w[k]}, 32'd0);
            check("rst_done", k, {31'd0, done_w[k]}, 32'd0);
            check("rst_ferr", k, {31'd0, ferr_w[k]}, 32'd0);
            check("rst_perr", k, {31'd0, perr_w[k]}, 32'd0);
            check("rst_busy", k, {31'd0, busy_w[k]}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        wait_ticks(2);

        // 8N1 basic
        send_frame(0, 8'hA5, 1'b0, 1'b1, 2);
        check("basic_dout", 0, {24'd0, dout_w[0]}, 32'h0000_00A5);
        check("basic_ferr", 0, {31'd0, ferr_w[0]}, 32'd0);
        check("basic_busy", 0, {31'd0, busy_w[0]}, 32'd0);
        check("basic_count", 0, done_cnt[0], 32'd1);

        // Glitch rejection
        cnt = done_cnt[0];
        busy_seen[0] = 1'b0;
        rx_line[0] = 1'b0;
        wait_ticks(5);
        rx_line[0] = 1'b1;
        wait_ticks(20);
        check("glitch_busy_seen", 0, {31'd0, busy_seen[0]}, 32'd1);
        check("glitch_busy_after", 0, {31'd0, busy_w[0]}, 32'd0);
        check("glitch_no_done", 0, done_cnt[0], cnt);

        // Framing error, then a good frame
        send_frame(0, 8'h3C, 1'b0, 1'b0, 16);
        check("ferr_dout", 0, {24'd0, dout_w[0]}, 32'h0000_003C);
        check("ferr_set", 0, {31'd0, ferr_w[0]}, 32'd1);
        send_frame(0, 8'h55, 1'b0, 1'b1, 2);
        check("ferr_clear", 0, {31'd0, ferr_w[0]}, 32'd0);

        // Parity, even then odd
        send_frame(1, 8'h07, 1'b1, 1'b1, 2);
        check("even_p1", 1, {31'd0, perr_w[1]}, 32'd0);
        send_frame(1, 8'h07, 1'b0, 1'b1, 2);
        check("even_p0", 1, {31'd0, perr_w[1]}, 32'd1);
        send_frame(2, 8'h07, 1'b1, 1'b1, 2);
        check("odd_p1", 2, {31'd0, perr_w[2]}, 32'd1);
        send_frame(2, 8'h07, 1'b0, 1'b1, 2);
        check("odd_p0", 2, {31'd0, perr_w[2]}, 32'd0);

        // Back-to-back frames with no idle gap
        cnt = done_cnt[0];
        send_frame(0, 8'h00, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 2);
        check("b2b_count", 0, done_cnt[0], cnt + 3);
        check("b2b_last", 0, {24'd0, dout_w[0]}, 32'h0000_0081);

        // Randomised frames on all three receivers
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                d = 8'($urandom_range(0, 255));
                send_frame(k, d, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
            end
        end

        // Reset in the middle of the 4th data bit of 0x5A
        send_frame(0, 8'h99, 1'b0, 1'b1, 2);
        d = 8'h5A;
        rx_line[0] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_line[0] = d[i];
            wait_ticks(16);
        end
        rx_line[0] = d[3];
        wait_ticks(8);
        reset = 1'b0;
        clear_model();
        rx_line[0] = 1'b1;
        #1;
        check("mid_rst_dout", 0, {24'd0, dout_w[0]}, 32'd0);
        check("mid_rst_busy", 0, {31'd0, busy_w[0]}, 32'd0);
        check("mid_rst_done", 0, {31'd0, done_w[0]}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        wait_ticks(4);
        cnt = done_cnt[0];
        send_frame(0, 8'h12, 1'b0, 1'b1, 4);
        check("post_rst_dout", 0, {24'd0, dout_w[0]}, 32'h0000_0012);
        check("post_rst_count", 0, done_cnt[0], cnt + 1);

        for (int k = 0; k < 3; k++) begin
            check("queue_drained", k, expq[k].size(), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
UART receiver that consumes the 16x-oversampling baud tick from the mod-M baud counter and deserialises the asynchronous rx line into parallel data words.
- Sits between the board RX pin and the command/FIFO logic of the voltage display instrument.
- Reports a one-cycle done strobe with each word, plus framing and parity error flags.

Parameters:
DBIT, 8, number of data bits per frame (5..9), LSB first.
SB_TICK, 16, stop-bit length in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
clk  input  1  system clock.
reset  input  1  reset, asynchronous assert, active-low (0 = reset).
rx  input  1  asynchronous serial line, idle high.
s_tick  input  1  one-clk pulse at 16x baud rate (max_tick of the baud mod-M counter).
dout  output  DBIT  last received data word.
rx_done_tick  output  1  one-clk pulse: dout, frame_err and parity_err are valid.
frame_err  output  1  stop bit sampled low for the word just completed.
parity_err  output  1  parity mismatch for the word just completed (always 0 when PARITY=0).
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset values (async, reset=0):
- Synchroniser flops = 1, FSM = IDLE, s = 0, n = 0, shift register = 0.
- dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, busy = 0.
- Reset mid-frame aborts the frame; no done pulse is issued.

Input path:
- rx passes through a 2-flop synchroniser (rx_s).
- Only rx_s is used internally.

FSM advancement:
- Advances only on clk edges with s_tick = 1, except the IDLE exit.
- With no s_tick, all state holds.
- s is a 5-bit tick counter; n is the bit counter, ceil(log2(DBIT)) bits.

States:
- IDLE: when rx_s = 0, go to START with s = 0 on that clk, independent of s_tick.
- START, on s_tick:
  - If s = 7 and rx_s = 0: go to DATA with s = 0, n = 0 (mid start bit confirmed).
  - If s = 7 and rx_s = 1: glitch; return to IDLE with no outputs.
  - Otherwise s = s + 1.
- DATA, on s_tick:
  - If s = 15: s = 0, shift = {rx_s, shift[DBIT-1:1]}.
  - Then if n = DBIT-1, go to PARITY (PARITY != 0) or STOP; otherwise n = n + 1.
  - Otherwise s = s + 1.
- PARITY, on s_tick:
  - If s = 15: capture par_bit = rx_s, s = 0, go to STOP.
  - Otherwise s = s + 1.
- STOP, on s_tick:
  - If s = SB_TICK-1: sample rx_s, go to IDLE, and register outputs on the same edge:
    - dout = shift.
    - frame_err = ~rx_s.
    - parity_err = (PARITY != 0) & (^shift ^ par_bit ^ (PARITY == 2)).
    - rx_done_tick = 1.
  - Otherwise s = s + 1.

Timing and output rules:
- rx_done_tick stays high for exactly one clk. It is cleared on the next clk regardless of s_tick.
- dout, frame_err and parity_err hold until the next rx_done_tick. They are not cleared between frames.
- A word with frame_err = 1 is still delivered in dout. Error handling is the consumer's job.
- Latency: rx_done_tick rises 1 clk after the s_tick edge where STOP reaches s = SB_TICK-1, which is mid stop bit for SB_TICK = 16. The 2-clk synchroniser delay is added on top relative to the rx pin.
- Back-to-back frames: after STOP returns to IDLE, a start edge already low on the next clk is accepted immediately. No extra idle time is required.
- Line held low (break): the first frame completes with frame_err = 1. The FSM then re-enters START from IDLE and produces frames with dout = 0 and frame_err = 1 for as long as rx stays low.
- s_tick coincident with the IDLE->START transition is ignored for counting; s starts at 0.

Test Plan:
1. 8N1 basic: reset low for 3 clks, then s_tick every 4 clks. Send 0xA5 at 16 ticks/bit -> one rx_done_tick, dout = 0xA5, frame_err = 0, parity_err = 0, busy low after the pulse.
2. Glitch reject: rx low for 5 s_ticks, then high -> FSM returns to IDLE, no rx_done_tick, busy pulses then returns to 0.
3. Framing error: send 0x3C with stop bit driven 0 -> rx_done_tick, dout = 0x3C, frame_err = 1. A following 0x55 with a good stop bit gives frame_err = 0.
4. Parity (PARITY = 1): send 0x07 with parity bit 1 -> parity_err = 0. Send 0x07 with parity bit 0 -> parity_err = 1. Repeat with PARITY = 2 and expect the inverted results.
5. Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap -> three rx_done_ticks, dout values in order, no errors.
6. Reset mid-frame: assert reset during the 4th data bit of 0x5A -> outputs = 0 immediately (async). After release, a fresh 0x12 is received correctly with no spurious done pulse.
